// File: rtl/uart_proto_pkg.sv
// Shared protocol definitions for the UART memory server: command codes,
// default response bytes and the server FSM state encoding.
package uart_proto_pkg;

    localparam logic [7:0] CMD_READ    = 8'h01;
    localparam logic [7:0] CMD_WRITE   = 8'h02;
    localparam logic [7:0] ACK_DEFAULT = 8'hAA;
    localparam logic [7:0] NAK_DEFAULT = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_MASK,
        S_DATA,
        S_MEM_RD,
        S_MEM_CAP,
        S_MEM_WR,
        S_SEND,
        S_SEND_WAIT
    } srv_state_e;

endpackage

// File: rtl/uart_tx_queue.sv
// Up to four response bytes, shifted out LSB first. Each pop (taken only
// while the transmitter is idle) yields one registered tx_ce pulse and
// updates tx_data, which then stays put until the next pop.
module uart_tx_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_cnt,
    input  logic        pop,
    input  logic        tx_busy,
    output logic        tx_ce,
    output logic [7:0]  tx_data,
    output logic [2:0]  count
);

    logic [31:0] shift_q;
    logic [2:0]  cnt_q;
    logic        tx_ce_q;
    logic [7:0]  tx_data_q;

    // Load a new response or emit the next byte when the line is free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            tx_ce_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_ce_q <= 1'b0;
            if (load) begin
                shift_q <= load_data;
                cnt_q   <= load_cnt;
            end else if (pop && !tx_busy && cnt_q != 3'd0) begin
                tx_ce_q   <= 1'b1;
                tx_data_q <= shift_q[7:0];
                shift_q   <= {8'h00, shift_q[31:8]};
                cnt_q     <= cnt_q - 3'd1;
            end
        end
    end

    assign tx_ce   = tx_ce_q;
    assign tx_data = tx_data_q;
    assign count   = cnt_q;

endmodule

// File: rtl/uart_mem_server.sv
// Remote end of the UART memory bridge: parses read/write frames, issues a
// single-cycle memory strobe and returns read data, ACK or NAK bytes.
module uart_mem_server
    import uart_proto_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_fault,
    output logic        tx_ce,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byte,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam int              GAP_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES);

    srv_state_e       state_q;
    logic [1:0]       byte_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             is_write_q;
    logic             wait_q;
    logic             err_q;
    logic             mem_ce_q;
    logic             mem_we_q;
    logic [31:0]      addr_q;
    logic [3:0]       mem_byte_q;
    logic [31:0]      data_q;

    logic             rx_byte;
    logic             q_load_d;
    logic [31:0]      q_data_d;
    logic [2:0]       q_cnt_d;
    logic             q_pop_d;
    logic [2:0]       q_count;

    // A faulted byte is never accepted.
    assign rx_byte = rx_valid && !rx_fault;

    // Queue loading for NAK, read data and ACK; pops while in SEND.
    always_comb begin
        q_load_d = 1'b0;
        q_data_d = '0;
        q_cnt_d  = '0;
        q_pop_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_byte && rx_data != CMD_READ && rx_data != CMD_WRITE) begin
                    q_load_d = 1'b1;
                    q_data_d = {24'h0, NAK_BYTE};
                    q_cnt_d  = 3'd1;
                end
            end
            S_MEM_CAP: begin
                q_load_d = 1'b1;
                q_data_d = mem_rdata;
                q_cnt_d  = 3'd4;
            end
            S_MEM_WR: begin
                q_load_d = 1'b1;
                q_data_d = {24'h0, ACK_BYTE};
                q_cnt_d  = 3'd1;
            end
            S_SEND:  q_pop_d = 1'b1;
            default: ;
        endcase
    end

    // Frame parser, memory sequencer and response handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            is_write_q <= 1'b0;
            wait_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            mem_byte_q <= '0;
            data_q     <= '0;
        end else begin
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (rx_fault) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    gap_cnt_q  <= '0;
                    byte_cnt_q <= '0;
                    if (rx_byte) begin
                        if (rx_data == CMD_READ) begin
                            is_write_q <= 1'b0;
                            state_q    <= S_ADDR;
                        end else if (rx_data == CMD_WRITE) begin
                            is_write_q <= 1'b1;
                            state_q    <= S_ADDR;
                        end else begin
                            state_q <= S_SEND;
                        end
                    end
                end
                S_ADDR, S_MASK, S_DATA: begin
                    if (rx_fault) begin
                        state_q <= S_IDLE;
                    end else if (rx_valid) begin
                        gap_cnt_q <= '0;
                        if (state_q == S_ADDR) begin
                            addr_q     <= {rx_data, addr_q[31:8]};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                if (is_write_q) begin
                                    state_q <= S_MASK;
                                end else begin
                                    state_q    <= S_MEM_RD;
                                    mem_ce_q   <= 1'b1;
                                    mem_byte_q <= 4'hF;
                                end
                            end
                        end else if (state_q == S_MASK) begin
                            mem_byte_q <= rx_data[3:0];
                            state_q    <= S_DATA;
                        end else begin
                            data_q     <= {rx_data, data_q[31:8]};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                state_q  <= S_MEM_WR;
                                mem_ce_q <= 1'b1;
                                mem_we_q <= 1'b1;
                            end
                        end
                    end else if (gap_cnt_q == GAP_MAX) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                S_MEM_RD:  state_q <= S_MEM_CAP;
                S_MEM_CAP: state_q <= S_SEND;
                S_MEM_WR:  state_q <= S_SEND;
                S_SEND: begin
                    if (!tx_busy) begin
                        state_q <= S_SEND_WAIT;
                        wait_q  <= 1'b1;
                    end
                end
                S_SEND_WAIT: begin
                    if (wait_q) begin
                        wait_q <= 1'b0;
                    end else if (!tx_busy) begin
                        state_q <= (q_count == 3'd0) ? S_IDLE : S_SEND;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Bytes arriving while the server is busy responding are lost.
            if (rx_byte && (state_q == S_MEM_RD || state_q == S_MEM_CAP ||
                            state_q == S_MEM_WR || state_q == S_SEND ||
                            state_q == S_SEND_WAIT)) begin
                err_q <= 1'b1;
            end
        end
    end

    uart_tx_queue u_txq (
        .clk       (clk),
        .rst       (rst),
        .load      (q_load_d),
        .load_data (q_data_d),
        .load_cnt  (q_cnt_d),
        .pop       (q_pop_d),
        .tx_busy   (tx_busy),
        .tx_ce     (tx_ce),
        .tx_data   (tx_data),
        .count     (q_count)
    );

    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_byte  = mem_byte_q;
    assign mem_wdata = data_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;

endmodule

// File: doc/uart_mem_server.md
UART_MEM_SERVER -- requirements
Module: uart_mem_server

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum clk cycles allowed between consecutive bytes of one frame.
REQ-002 SHALL have parameter ACK_BYTE, default 8'hAA: write-acknowledge byte.
REQ-003 SHALL have parameter NAK_BYTE, default 8'hEE: bad-command response byte.
REQ-004 SHALL have clk  input  1  system clock; one clock domain, all logic on the rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have rx_valid  input  1  one-cycle pulse: rx_data holds a received byte.
REQ-007 SHALL have rx_data  input  8  received byte.
REQ-008 SHALL have rx_fault  input  1  one-cycle pulse: receiver framing error.
REQ-009 SHALL have tx_ce  output  1  one-cycle pulse: start transmitting tx_data.
REQ-010 SHALL have tx_data  output  8  byte to transmit; held from the tx_ce pulse until tx_busy falls.
REQ-011 SHALL have tx_busy  input  1  transmitter busy; rises no later than 1 cycle after tx_ce.
REQ-012 SHALL have mem_ce, mem_we  output  1 each  local memory strobe and write enable; 1-cycle pulses.
REQ-013 SHALL have mem_addr  output  32, mem_byte  output  4, mem_wdata  output  32  memory address, byte lanes, write data.
REQ-014 SHALL have mem_rdata  input  32  read data, valid exactly 1 cycle after a read strobe.
REQ-015 SHALL have busy  output  1 (high when state != IDLE) and err  output  1 (sticky error flag).

Function
REQ-016 SHALL service frames as the remote end of the CPU-side UART bridge; all multi-byte fields are little-endian.
- Read frame: 8'h01, A0..A3.
- Write frame: 8'h02, A0..A3, MASK (low nibble = byte lanes), D0..D3.
REQ-017 SHALL implement these FSM states: IDLE, ADDR (4 bytes), MASK, DATA (4 bytes), MEM_RD, MEM_CAP, MEM_WR, SEND, SEND_WAIT.
REQ-018 In IDLE, rx_valid SHALL select the next state:
- 8'h01 -> ADDR, read.
- 8'h02 -> ADDR, write.
- Any other byte -> SEND with NAK_BYTE.
REQ-019 After the 4th address byte, a read SHALL go to MEM_RD and a write SHALL go to MASK; a 2-bit byte counter SHALL wrap 3->0.
REQ-020 MEM_RD SHALL pulse mem_ce=1, mem_we=0, mem_byte=4'hF.
REQ-021 MEM_CAP SHALL latch mem_rdata into a 32-bit shift register on the next cycle, then go to SEND with 4 bytes queued, LSB first.
REQ-022 After D3, MEM_WR SHALL pulse mem_ce=1, mem_we=1 with the latched addr/mask/data, then go to SEND with 1 byte (ACK_BYTE).
REQ-023 SEND SHALL assert tx_ce only when tx_busy=0, then go to SEND_WAIT.
REQ-024 SEND_WAIT SHALL ignore tx_busy for 1 cycle, then wait for tx_busy=0, then either send the next queued byte or return to IDLE.
REQ-025 Request-to-memory latency SHALL be exactly 1 cycle: the strobe is issued the cycle after the final request byte is accepted.
REQ-026 Bytes arriving in MEM_*, SEND or SEND_WAIT SHALL be dropped and SHALL set err.
REQ-027 rx_fault in any receive state (ADDR, MASK, DATA) SHALL abort to IDLE and set err; in IDLE it SHALL only set err.
REQ-028 A gap counter SHALL reset on every accepted byte; in ADDR/MASK/DATA, reaching TIMEOUT_CYCLES SHALL abort to IDLE and set err.
REQ-029 When rx_valid and rx_fault occur in the same cycle, rx_fault SHALL win and the byte SHALL be discarded.
REQ-030 err SHALL clear only on reset.

Reset
REQ-031 While rst=0 at a clock edge, the block SHALL enter IDLE and drive tx_ce, mem_ce, mem_we, busy, err = 0 and tx_data, mem_addr, mem_wdata = 0, mem_byte = 4'h0, all counters 0.
REQ-032 Reset mid-frame or mid-send SHALL discard all partial state; no strobe SHALL be issued in the cycle after reset release.

Structure
REQ-033 SHALL place command codes (8'h01, 8'h02), default ACK/NAK values and the FSM state encoding in shared package uart_proto_pkg, also used by uart_top.
REQ-034 SHALL contain one sub-module, uart_tx_queue: a 4-byte shift/count unit driving tx_ce/tx_data with the tx_busy handshake.

Verification
REQ-035 Read: bytes 01 10 00 00 00; memory returns 32'hDEADBEEF at 0x10 -> one read strobe with mem_addr=0x00000010, then tx bytes EF BE AD DE in order.
REQ-036 Write: 02 04 00 00 00 03 78 56 34 12 -> one write strobe with mem_addr=0x4, mem_byte=4'h3, mem_wdata=0x12345678, then tx byte AA.
REQ-037 Bad command: byte 7F -> tx byte EE, no memory strobe, FSM back in IDLE.
REQ-038 Timeout: send 01 20, then idle TIMEOUT_CYCLES (bench sets 50) -> err=1, busy=0; a following valid read frame completes normally.
REQ-039 Fault: rx_fault during DATA -> abort with no write strobe, err=1.
REQ-040 Slow transmitter: tx_busy held high 1000 cycles per byte during a read response -> 4 tx_ce pulses total, each issued only while tx_busy=0.
REQ-041 Reset: rst=0 asserted mid-response -> outputs at reset values on the next edge, no further tx_ce.
